adder_share_arbiter: RTL and testbench

//  Shares one W-bit adder datapath (sum = a + b) between NUM_REQ requesters.

---
 rtl/adder_share_arbiter.sv | 143 ++++++++++++++
 tb/tb_adder_share_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter: one W-bit adder shared by NUM_REQ requesters.
// A round-robin grant in IDLE captures operands. CALC performs the add, and RESP
// holds the result until the consumer accepts it.
// Optional build macro ADDER_SHARE_XOR_MIX_EN: XOR operand b into the result data.
module adder_share_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned W       = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*W-1:0]       req_a,
  input  logic [NUM_REQ*W-1:0]       req_b,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       resp_valid,
  output logic [$clog2(NUM_REQ)-1:0] resp_id,
  output logic [W-1:0]               resp_data,
  output logic                       resp_carry,
  input  logic                       resp_ready,
  output logic                       busy
);

  localparam int unsigned IDW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {StIdle, StCalc, StResp} state_e;

  state_e           state_q, state_d;
  logic [W-1:0]     a_q, b_q;
  logic [IDW-1:0]   id_q;
  logic [IDW-1:0]   rr_ptr_q;
  logic             resp_valid_q;
  logic [IDW-1:0]   resp_id_q;
  logic [W-1:0]     resp_data_q;
  logic             resp_carry_q;

  logic [W-1:0]     a_arr [NUM_REQ];
  logic [W-1:0]     b_arr [NUM_REQ];
  logic [NUM_REQ-1:0] grant;
  logic [IDW-1:0]   grant_id;
  logic [IDW-1:0]   idx;
  logic             found;
  logic             handshake;
  logic [W:0]       sum_full;
  logic [W-1:0]     calc_data;

  // Unpack the flat operand buses into per-requester lanes
  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      a_arr[i] = req_a[i*W +: W];
      b_arr[i] = req_b[i*W +: W];
    end
  end

  // Round-robin search starting at rr_ptr, wrapping modulo NUM_REQ
  always_comb begin
    grant    = '0;
    grant_id = '0;
    idx      = '0;
    found    = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = IDW'((32'(rr_ptr_q) + k) % NUM_REQ);
      if (!found && req_valid[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_id   = idx;
      end
    end
  end

  // Shared adder; optional XOR mix only alters the data, never the carry
  always_comb begin
    sum_full = {1'b0, a_q} + {1'b0, b_q};
`ifdef ADDER_SHARE_XOR_MIX_EN
    calc_data = sum_full[W-1:0] ^ b_q;
`else
    calc_data = sum_full[W-1:0];
`endif
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (found) state_d = StCalc;
      StCalc:  state_d = StResp;
      StResp:  if (resp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs: grants only in IDLE and never while reset is asserted
  always_comb begin
    req_ready  = '0;
    if (!rst && (state_q == StIdle)) req_ready = grant;
    busy       = (state_q == StCalc) || (state_q == StResp);
    resp_valid = resp_valid_q;
    resp_id    = resp_id_q;
    resp_data  = resp_data_q;
    resp_carry = resp_carry_q;
  end

  assign handshake = (state_q == StIdle) && found;

  // Datapath: operand capture, result register and round-robin pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q          <= '0;
      b_q          <= '0;
      id_q         <= '0;
      rr_ptr_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_data_q  <= '0;
      resp_carry_q <= 1'b0;
    end else begin
      if (handshake) begin
        a_q  <= a_arr[grant_id];
        b_q  <= b_arr[grant_id];
        id_q <= grant_id;
      end
      if (state_q == StCalc) begin
        resp_data_q  <= calc_data;
        resp_carry_q <= sum_full[W];
        resp_id_q    <= id_q;
        resp_valid_q <= 1'b1;
      end
      if ((state_q == StResp) && resp_ready) begin
        resp_valid_q <= 1'b0;
        rr_ptr_q     <= IDW'((32'(id_q) + 32'd1) % NUM_REQ);
      end
    end
  end

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Bench for adder_share_arbiter with NUM_REQ=4 and W=16.
// Directed scenarios are followed by randomized transactions. Every check
// compares the DUT against a behavioural model of grant order and addition.
module tb_adder_share_arbiter;

  localparam int NUM = 4;
  localparam int W   = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [NUM-1:0]  req_valid;
  logic [NUM*W-1:0] req_a;
  logic [NUM*W-1:0] req_b;
  logic [NUM-1:0]  req_ready;
  logic            resp_valid;
  logic [1:0]      resp_id;
  logic [W-1:0]    resp_data;
  logic            resp_carry;
  logic            resp_ready;
  logic            busy;

  int n_checks = 0;
  int n_errors = 0;
  int ptr      = 0;   // model of the round-robin start position
  int cyc      = 0;

  adder_share_arbiter #(.NUM_REQ(NUM), .W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_id    (resp_id),
    .resp_data  (resp_data),
    .resp_carry (resp_carry),
    .resp_ready (resp_ready),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // First requester with valid set, scanning from p upward and wrapping
  function automatic int model_grant(input logic [NUM-1:0] m, input int p);
    for (int k = 0; k < NUM; k++) begin
      if (m[(p + k) % NUM]) return (p + k) % NUM;
    end
    return -1;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    ptr = 0;
  endtask

  // One full transaction; bp = cycles of backpressure while in RESP
  task automatic txn(input logic [NUM-1:0] mask, input int bp);
    int g;
    int unsigned s;
    logic [W-1:0] ea, eb, ed;
    logic ec;
    req_valid  = mask;
    resp_ready = (bp == 0);
    #1;
    g = model_grant(mask, ptr);
    if (g < 0) begin
      chk("idle_ready", 32'(req_ready), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
      step();
      chk("idle_valid", 32'(resp_valid), 32'd0);
      return;
    end
    chk("grant", 32'(req_ready), 32'(1 << g));
    chk("idle_busy", 32'(busy), 32'd0);
    ea = req_a[g*W +: W];
    eb = req_b[g*W +: W];
    s  = 32'(ea) + 32'(eb);
    ed = s[15:0];
    ec = s[16];
`ifdef ADDER_SHARE_XOR_MIX_EN
    ed = ed ^ eb;
`endif
    step();
    chk("calc_ready", 32'(req_ready), 32'd0);
    chk("calc_busy", 32'(busy), 32'd1);
    chk("calc_valid", 32'(resp_valid), 32'd0);
    step();
    for (int c = 0; c < bp; c++) begin
      chk("hold_valid", 32'(resp_valid), 32'd1);
      chk("hold_id", 32'(resp_id), 32'(g));
      chk("hold_data", 32'(resp_data), 32'(ed));
      chk("hold_carry", 32'(resp_carry), 32'(ec));
      chk("hold_busy", 32'(busy), 32'd1);
      chk("hold_ready", 32'(req_ready), 32'd0);
      step();
    end
    resp_ready = 1'b1;
    #1;
    chk("resp_valid", 32'(resp_valid), 32'd1);
    chk("resp_id", 32'(resp_id), 32'(g));
    chk("resp_data", 32'(resp_data), 32'(ed));
    chk("resp_carry", 32'(resp_carry), 32'(ec));
    chk("resp_no_grant", 32'(req_ready), 32'd0);
    step();
    ptr = (g + 1) % NUM;
    chk("done_valid", 32'(resp_valid), 32'd0);
    chk("done_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    int t0;
    rst        = 1'b1;
    req_valid  = 4'b1111;
    req_a      = '0;
    req_b      = '0;
    resp_ready = 1'b0;

    // Reset held two cycles with every requester valid
    for (int i = 0; i < 2; i++) begin
      step();
      chk("rst_ready", 32'(req_ready), 32'd0);
      chk("rst_valid", 32'(resp_valid), 32'd0);
      chk("rst_data", 32'(resp_data), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
    end
    rst = 1'b0;
    ptr = 0;

    // Single requester 2: 11 + 22
    req_a = {$urandom, $urandom};
    req_b = {$urandom, $urandom};
    req_a[2*W +: W] = 16'd11;
    req_b[2*W +: W] = 16'd22;
    txn(4'b0100, 0);

    // Fairness from a fresh pointer: ids 0,1,2,3,0, three cycles each
    req_valid = 4'b0000;
    do_reset();
    t0 = cyc;
    for (int i = 0; i < 5; i++) begin
      chk("fair_order", 32'(model_grant(4'b1111, ptr)), 32'(i % NUM));
      req_a = {$urandom, $urandom};
      req_b = {$urandom, $urandom};
      txn(4'b1111, 0);
    end
    chk("throughput", 32'(cyc - t0), 32'd15);

    // Overflow wraps and reports carry
    req_a[0 +: W] = 16'hFFFF;
    req_b[0 +: W] = 16'h0002;
    txn(4'b0001, 0);

    // Backpressure for five cycles, then next grant continues from id+1
    req_a = {$urandom, $urandom};
    req_b = {$urandom, $urandom};
    txn(4'b0110, 5);
    txn(4'b0110, 0);

    // Reset during CALC drops the transaction
    req_valid  = 4'b1010;
    resp_ready = 1'b1;
    #1;
    chk("midop_grant", 32'(req_ready), 32'(1 << model_grant(4'b1010, ptr)));
    step();
    chk("midop_calc", 32'(busy), 32'd1);
    req_valid = 4'b0000;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      chk("midop_valid", 32'(resp_valid), 32'd0);
      chk("midop_busy", 32'(busy), 32'd0);
      step();
    end
    req_a = {$urandom, $urandom};
    req_b = {$urandom, $urandom};
    txn(4'b1100, 0);

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      req_a = {$urandom, $urandom};
      req_b = {$urandom, $urandom};
      txn(4'($urandom_range(0, 15)), int'($urandom_range(0, 2)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
